// File: rtl/pipe_pkg.sv
// Shared decode/execute definitions: field widths, bundle layout, one-hot bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Imported by decode, the pipe_reg_e register and execute so every stage agrees on the bundle layout.
package pipe_pkg;

    localparam int XLEN  = 64;
    localparam int ALU_W = 28;
    localparam int OPC_W = 12;
    localparam int BR_W  = 6;
    localparam int LS_W  = 11;
    localparam int RD_W  = 5;

    // opcode_info one-hot positions
    localparam int OPC_LUI      = 11;
    localparam int OPC_AUIPC    = 10;
    localparam int OPC_JAL      = 9;
    localparam int OPC_JALR     = 8;
    localparam int OPC_BRANCH   = 7;
    localparam int OPC_LOAD     = 6;
    localparam int OPC_STORE    = 5;
    localparam int OPC_OP_IMM   = 4;
    localparam int OPC_OP       = 3;
    localparam int OPC_OP_IMM_W = 2;
    localparam int OPC_OP_W     = 1;
    localparam int OPC_SYSTEM   = 0;

    // branch_info one-hot positions
    localparam int BR_BEQ  = 5;
    localparam int BR_BNE  = 4;
    localparam int BR_BLT  = 3;
    localparam int BR_BGE  = 2;
    localparam int BR_BLTU = 1;
    localparam int BR_BGEU = 0;

    typedef struct packed {
        logic [ALU_W-1:0] alu_info;
        logic [OPC_W-1:0] opcode_info;
        logic [BR_W-1:0]  branch_info;
        logic [LS_W-1:0]  load_store_info;
        logic [XLEN-1:0]  regdata1;
        logic [XLEN-1:0]  regdata2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [RD_W-1:0]  rd;
    } e_bundle_t;

    // Occupancy of the main/skid slot pair.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_reg_e_if.sv
// Decode -> pipe_reg_e -> execute handshake and bundle bus.
// Latency: n/a (wires only).
// Backpressure: regE_o_ready toward decode, execute_i_ready from execute; flush_i from execute.
// Modports: slave = the pipeline register, master = the decode/execute side driving it.
interface pipe_reg_e_if;
    import pipe_pkg::*;

    logic              decode_i_valid;
    logic              regE_o_ready;
    logic [ALU_W-1:0]  decode_i_alu_info;
    logic [OPC_W-1:0]  decode_i_opcode_info;
    logic [BR_W-1:0]   decode_i_branch_info;
    logic [LS_W-1:0]   decode_i_load_store_info;
    logic [XLEN-1:0]   decode_i_regdata1;
    logic [XLEN-1:0]   decode_i_regdata2;
    logic [XLEN-1:0]   decode_i_imm;
    logic [XLEN-1:0]   decode_i_pc;
    logic [RD_W-1:0]   decode_i_rd;

    logic              regE_o_valid;
    logic              execute_i_ready;
    logic [ALU_W-1:0]  regE_o_alu_info;
    logic [OPC_W-1:0]  regE_o_opcode_info;
    logic [BR_W-1:0]   regE_o_branch_info;
    logic [LS_W-1:0]   regE_o_load_store_info;
    logic [XLEN-1:0]   regE_o_regdata1;
    logic [XLEN-1:0]   regE_o_regdata2;
    logic [XLEN-1:0]   regE_o_imm;
    logic [XLEN-1:0]   regE_o_pc;
    logic [RD_W-1:0]   regE_o_rd;

    logic              flush_i;

    modport slave (
        input  decode_i_valid, decode_i_alu_info, decode_i_opcode_info, decode_i_branch_info,
               decode_i_load_store_info, decode_i_regdata1, decode_i_regdata2, decode_i_imm,
               decode_i_pc, decode_i_rd, execute_i_ready, flush_i,
        output regE_o_ready, regE_o_valid, regE_o_alu_info, regE_o_opcode_info,
               regE_o_branch_info, regE_o_load_store_info, regE_o_regdata1, regE_o_regdata2,
               regE_o_imm, regE_o_pc, regE_o_rd
    );

    modport master (
        output decode_i_valid, decode_i_alu_info, decode_i_opcode_info, decode_i_branch_info,
               decode_i_load_store_info, decode_i_regdata1, decode_i_regdata2, decode_i_imm,
               decode_i_pc, decode_i_rd, execute_i_ready, flush_i,
        input  regE_o_ready, regE_o_valid, regE_o_alu_info, regE_o_opcode_info,
               regE_o_branch_info, regE_o_load_store_info, regE_o_regdata1, regE_o_regdata2,
               regE_o_imm, regE_o_pc, regE_o_rd
    );

endinterface

// File: rtl/skid_slot.sv
// One bundle register plus valid bit; clear wins over load and zeroes the data (bubble).
// Latency: 1 cycle from load to q.
// Backpressure: none; the parent decides when to load or clear.
// Ports: clk, rst_n, load, clear, d (bundle in), q (bundle out), vld.
module skid_slot
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  logic      clear,
    input  e_bundle_t d,
    output e_bundle_t q,
    output logic      vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (clear) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (load) begin
            q   <= d;
            vld <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_reg_e.sv
// Decode-to-execute pipeline register with a two-entry skid buffer and registered ready.
// Latency: 1 cycle; 1 bundle/cycle throughput while execute_i_ready stays high.
// Backpressure: skid slot absorbs the bundle in flight when execute stalls; ready drops only when both slots are full.
// Ports: clk, rst_n, bus (pipe_reg_e_if.slave: decode_i_* in, regE_o_* out, execute_i_ready, flush_i).
module pipe_reg_e
    import pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    pipe_reg_e_if.slave   bus
);

    occ_e      state;
    occ_e      state_nxt;
    logic      ready_q;
    e_bundle_t din;
    e_bundle_t m_d;
    e_bundle_t m_q;
    e_bundle_t s_q;
    logic      m_vld;
    logic      s_vld;
    logic      m_load, m_clr, s_load, s_clr;
    logic      up, down;

    assign din = '{
        alu_info:        bus.decode_i_alu_info,
        opcode_info:     bus.decode_i_opcode_info,
        branch_info:     bus.decode_i_branch_info,
        load_store_info: bus.decode_i_load_store_info,
        regdata1:        bus.decode_i_regdata1,
        regdata2:        bus.decode_i_regdata2,
        imm:             bus.decode_i_imm,
        pc:              bus.decode_i_pc,
        rd:              bus.decode_i_rd
    };

    assign up   = bus.decode_i_valid & ready_q;
    assign down = m_vld & bus.execute_i_ready;

    always_comb begin
        m_load    = 1'b0;
        m_clr     = 1'b0;
        s_load    = 1'b0;
        s_clr     = 1'b0;
        m_d       = din;
        state_nxt = state;
        if (bus.flush_i) begin
            // Flush beats everything; a bundle offered this cycle is dropped.
            m_clr     = 1'b1;
            s_clr     = 1'b1;
            state_nxt = OCC_EMPTY;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (up) begin
                        m_load    = 1'b1;
                        state_nxt = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (up && down) begin
                        m_load = 1'b1;
                    end else if (up) begin
                        s_load    = 1'b1;
                        state_nxt = OCC_TWO;
                    end else if (down) begin
                        m_clr     = 1'b1;
                        state_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // ready is low here, so only the skid-to-main move can happen.
                    if (down) begin
                        m_load    = 1'b1;
                        m_d       = s_q;
                        s_clr     = 1'b1;
                        state_nxt = OCC_ONE;
                    end
                end
                default: state_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OCC_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != OCC_TWO);
        end
    end

    skid_slot u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (m_load),
        .clear (m_clr),
        .d     (m_d),
        .q     (m_q),
        .vld   (m_vld)
    );

    skid_slot u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (s_load),
        .clear (s_clr),
        .d     (din),
        .q     (s_q),
        .vld   (s_vld)
    );

    // Main slot zeroes itself whenever invalid, so outputs are bubbles without extra muxing.
    assign bus.regE_o_ready           = ready_q;
    assign bus.regE_o_valid           = m_vld;
    assign bus.regE_o_alu_info        = m_q.alu_info;
    assign bus.regE_o_opcode_info     = m_q.opcode_info;
    assign bus.regE_o_branch_info     = m_q.branch_info;
    assign bus.regE_o_load_store_info = m_q.load_store_info;
    assign bus.regE_o_regdata1        = m_q.regdata1;
    assign bus.regE_o_regdata2        = m_q.regdata2;
    assign bus.regE_o_imm             = m_q.imm;
    assign bus.regE_o_pc              = m_q.pc;
    assign bus.regE_o_rd              = m_q.rd;

`ifndef SYNTHESIS
    a_info_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (up && !bus.flush_i) |-> ($onehot0(din.alu_info) && $onehot0(din.opcode_info) &&
                                  $onehot0(din.branch_info) && $onehot0(din.load_store_info)));

    a_opc_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (up && !bus.flush_i) |-> (din.opcode_info != '0));

    a_occ_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        ((state != OCC_EMPTY) == m_vld) && ((state == OCC_TWO) == s_vld));
`endif

endmodule

// File: tb/tb_pipe_reg_e.sv
// Self-checking bench for pipe_reg_e: directed vector table, reset/flush corners, random fuzz vs queue model.
// Latency: expects bundles on regE_o_* one cycle after acceptance.
// Backpressure: model holds at most two bundles; ready reflects whether the held count after the edge is below two.
module tb_pipe_reg_e;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_reg_e_if bus ();

    pipe_reg_e dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        dv;
        logic [15:0] pc;
        logic        er;
        logic        fl;
        logic        ev;
        logic        erdy;
        logic [15:0] epc;
    } vec_t;

    vec_t            tbl[20];
    logic [XLEN-1:0] consumed[$];
    logic [XLEN-1:0] exp_consumed[$];
    e_bundle_t       mq[$];

    function automatic e_bundle_t mk(input logic [XLEN-1:0] pc);
        e_bundle_t b;
        b                 = '0;
        b.alu_info        = ALU_W'(1) << pc[3:2];
        b.opcode_info     = OPC_W'(1) << OPC_LUI;
        b.branch_info     = '0;
        b.load_store_info = '0;
        b.regdata1        = pc * 3;
        b.regdata2        = ~pc;
        b.imm             = pc + 7;
        b.pc              = pc;
        b.rd              = pc[6:2];
        return b;
    endfunction

    function automatic e_bundle_t rnd_bundle();
        e_bundle_t b;
        int r;
        b = '0;
        r = $urandom_range(0, ALU_W);
        b.alu_info = (r == ALU_W) ? '0 : (ALU_W'(1) << r);
        b.opcode_info = OPC_W'(1) << $urandom_range(0, OPC_W - 1);
        r = $urandom_range(0, BR_W);
        b.branch_info = (r == BR_W) ? '0 : (BR_W'(1) << r);
        r = $urandom_range(0, LS_W);
        b.load_store_info = (r == LS_W) ? '0 : (LS_W'(1) << r);
        b.regdata1 = {$urandom, $urandom};
        b.regdata2 = {$urandom, $urandom};
        b.imm      = {$urandom, $urandom};
        b.pc       = {$urandom, $urandom};
        b.rd       = 5'($urandom);
        return b;
    endfunction

    function automatic e_bundle_t dut_out();
        e_bundle_t b;
        b.alu_info        = bus.regE_o_alu_info;
        b.opcode_info     = bus.regE_o_opcode_info;
        b.branch_info     = bus.regE_o_branch_info;
        b.load_store_info = bus.regE_o_load_store_info;
        b.regdata1        = bus.regE_o_regdata1;
        b.regdata2        = bus.regE_o_regdata2;
        b.imm             = bus.regE_o_imm;
        b.pc              = bus.regE_o_pc;
        b.rd              = bus.regE_o_rd;
        return b;
    endfunction

    task automatic drive(input logic v, input e_bundle_t b, input logic er, input logic fl);
        bus.decode_i_valid           = v;
        bus.decode_i_alu_info        = b.alu_info;
        bus.decode_i_opcode_info     = b.opcode_info;
        bus.decode_i_branch_info     = b.branch_info;
        bus.decode_i_load_store_info = b.load_store_info;
        bus.decode_i_regdata1        = b.regdata1;
        bus.decode_i_regdata2        = b.regdata2;
        bus.decode_i_imm             = b.imm;
        bus.decode_i_pc              = b.pc;
        bus.decode_i_rd              = b.rd;
        bus.execute_i_ready          = er;
        bus.flush_i                  = fl;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bun(input string name, input e_bundle_t act, input e_bundle_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pc=%h opc=%h bundle=%h expected pc=%h opc=%h bundle=%h (t=%0t)",
                     name, act.pc, act.opcode_info, act, exp.pc, exp.opcode_info, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        e_bundle_t b, prev_b, cur;
        logic      v, er, fl, up, down, hold, ready_m;

        drive(1'b0, '0, 1'b0, 1'b0);

        // Reset state
        #2;
        chk_bit("rst_valid", bus.regE_o_valid, 1'b0);
        chk_bit("rst_ready", bus.regE_o_ready, 1'b0);
        chk_bun("rst_bundle", dut_out(), '0);
        #10 rst_n = 1'b1;                 // t=12, between edges
        #1;
        chk_bit("rst_ready_before_edge", bus.regE_o_ready, 1'b0);
        @(posedge clk); #1;
        chk_bit("rst_ready_first_edge", bus.regE_o_ready, 1'b1);
        chk_bit("rst_valid_first_edge", bus.regE_o_valid, 1'b0);

        //          dv  pc        er  fl  ev  rdy  epc
        tbl[0]  = '{1, 16'h1000, 1, 0, 1, 1, 16'h1000};
        tbl[1]  = '{1, 16'h1004, 1, 0, 1, 1, 16'h1004};
        tbl[2]  = '{1, 16'h1008, 1, 0, 1, 1, 16'h1008};
        tbl[3]  = '{1, 16'h100C, 1, 0, 1, 1, 16'h100C};
        tbl[4]  = '{0, 16'h0000, 1, 0, 0, 1, 16'h0000};
        tbl[5]  = '{1, 16'h2000, 0, 0, 1, 1, 16'h2000};
        tbl[6]  = '{1, 16'h2004, 0, 0, 1, 0, 16'h2000};
        tbl[7]  = '{1, 16'h2008, 0, 0, 1, 0, 16'h2000};
        tbl[8]  = '{1, 16'h2008, 1, 0, 1, 1, 16'h2004};
        tbl[9]  = '{1, 16'h2008, 1, 0, 1, 1, 16'h2008};
        tbl[10] = '{0, 16'h0000, 1, 0, 0, 1, 16'h0000};
        tbl[11] = '{1, 16'h2100, 0, 0, 1, 1, 16'h2100};
        tbl[12] = '{1, 16'h2104, 0, 0, 1, 0, 16'h2100};
        tbl[13] = '{1, 16'h3000, 0, 1, 0, 1, 16'h0000};
        tbl[14] = '{1, 16'h3100, 0, 0, 1, 1, 16'h3100};
        tbl[15] = '{1, 16'h3000, 0, 1, 0, 1, 16'h0000};
        tbl[16] = '{0, 16'h0000, 0, 0, 0, 1, 16'h0000};
        tbl[17] = '{1, 16'h4000, 0, 0, 1, 1, 16'h4000};
        tbl[18] = '{0, 16'h0000, 1, 1, 0, 1, 16'h0000};
        tbl[19] = '{0, 16'h0000, 1, 0, 0, 1, 16'h0000};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].dv, mk(XLEN'(tbl[i].pc)), tbl[i].er, tbl[i].fl);
            if (bus.regE_o_valid && tbl[i].er)
                consumed.push_back(bus.regE_o_pc);
            @(posedge clk); #1;
            chk_bit($sformatf("vec%0d_valid", i), bus.regE_o_valid, tbl[i].ev);
            chk_bit($sformatf("vec%0d_ready", i), bus.regE_o_ready, tbl[i].erdy);
            chk_bun($sformatf("vec%0d_bundle", i), dut_out(),
                    tbl[i].ev ? mk(XLEN'(tbl[i].epc)) : e_bundle_t'('0));
        end

        // Every accepted, unflushed bundle consumed exactly once and in order.
        exp_consumed = '{64'h1000, 64'h1004, 64'h1008, 64'h100C,
                         64'h2000, 64'h2004, 64'h2008, 64'h4000};
        chk_int("consumed_count", consumed.size(), exp_consumed.size());
        for (int i = 0; i < exp_consumed.size() && i < consumed.size(); i++)
            chk_int($sformatf("consumed_%0d", i), consumed[i], exp_consumed[i]);

        // Async reset while both slots are full
        drive(1'b1, mk(64'h5000), 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, mk(64'h5004), 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_bit("two_ready_low", bus.regE_o_ready, 1'b0);
        chk_bun("two_main", dut_out(), mk(64'h5000));
        #3 rst_n = 1'b0;
        #1;
        chk_bit("arst_valid", bus.regE_o_valid, 1'b0);
        chk_bit("arst_ready", bus.regE_o_ready, 1'b0);
        chk_bun("arst_bundle", dut_out(), '0);
        drive(1'b0, '0, 1'b1, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_bit("arst_rel_ready", bus.regE_o_ready, 1'b1);
        chk_bit("arst_rel_valid", bus.regE_o_valid, 1'b0);
        @(posedge clk); #1;
        chk_bit("arst_skid_gone", bus.regE_o_valid, 1'b0);

        // Random fuzz against a bounded in-order queue model
        mq.delete();
        ready_m = 1'b1;
        hold    = 1'b0;
        prev_b  = '0;
        for (int c = 0; c < 10000; c++) begin
            cur = dut_out();
            chk_bit($sformatf("fz%0d_valid", c), bus.regE_o_valid, mq.size() != 0);
            chk_bit($sformatf("fz%0d_ready", c), bus.regE_o_ready, ready_m);
            chk_bun($sformatf("fz%0d_bundle", c), cur, (mq.size() != 0) ? mq[0] : e_bundle_t'('0));
            if (hold)
                chk_bun($sformatf("fz%0d_stable", c), cur, prev_b);

            v  = ($urandom_range(0, 9) < 7);
            er = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 99) < 3);
            b  = rnd_bundle();
            drive(v, b, er, fl);

            up     = v && ready_m;
            down   = (mq.size() != 0) && er;
            hold   = (mq.size() != 0) && !er && !fl;
            prev_b = cur;
            if (fl) begin
                mq.delete();
            end else begin
                if (down) void'(mq.pop_front());
                if (up) mq.push_back(b);
            end
            ready_m = (mq.size() < 2);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_reg_e.md
Name: pipe_reg_e

Overview:
- Decode-to-execute pipeline register with a two-entry skid buffer.
- Accepts decoded instruction bundles from decode over a valid/ready handshake and presents them on the regE_o_* fields that the execute stage consumes as regE_i_*.
- Ready toward decode is registered, which breaks the combinational ready path from execute.
- Empty slots and flushed slots present as bubbles: all one-hot info vectors are zero, so execute produces a zero result.

Parameters:
- XLEN, 64, width of the regdata1, regdata2, imm and pc fields.
- ALU_W, 28, width of alu_info.
- OPC_W, 12, width of opcode_info.
- BR_W, 6, width of branch_info.
- LS_W, 11, width of load_store_info.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- decode_i_valid  in  1  decode presents a bundle
- regE_o_ready  out  1  pipe_reg_e can accept this cycle; registered
- decode_i_alu_info  in  ALU_W  one-hot ALU op
- decode_i_opcode_info  in  OPC_W  one-hot opcode class; bit 11 = lui … bit 0 = system
- decode_i_branch_info  in  BR_W  one-hot branch op; bit 5 = beq … bit 0 = bgeu
- decode_i_load_store_info  in  LS_W  one-hot load/store op
- decode_i_regdata1, decode_i_regdata2, decode_i_imm, decode_i_pc  in  XLEN each  operands
- decode_i_rd  in  5  destination register
- regE_o_valid  out  1  execute-side bundle valid
- execute_i_ready  in  1  execute accepts the bundle this cycle
- regE_o_alu_info, regE_o_opcode_info, regE_o_branch_info, regE_o_load_store_info  out  same widths as inputs
- regE_o_regdata1, regE_o_regdata2, regE_o_imm, regE_o_pc  out  XLEN each
- regE_o_rd  out  5
- flush_i  in  1  kill all held bundles; asserted by execute on redirect

Behaviour:
- Handshake rules:
  - Upstream transfer occurs when decode_i_valid & regE_o_ready.
  - Downstream transfer occurs when regE_o_valid & execute_i_ready.
  - decode_i_valid may rise without waiting for ready.
  - Once regE_o_valid is high, the output bundle is held stable until a downstream transfer or a flush.
- Storage: a main slot M (drives the outputs) and a skid slot S.
- Occupancy states:
  - EMPTY: M and S invalid.
  - ONE: M valid, S invalid.
  - TWO: M and S valid.
- Transitions in EMPTY and ONE (no flush):
  - EMPTY + up → ONE; the bundle loads into M.
  - ONE + up + down → ONE; M reloads.
  - ONE + up, no down → TWO; the bundle loads into S.
  - ONE + down, no up → EMPTY.
- Transitions in TWO (no flush):
  - TWO + down → ONE; S moves to M.
  - No upstream transfer is possible in TWO because regE_o_ready is low.
- regE_o_ready = (next state != TWO), registered. In EMPTY and ONE it is 1; in TWO it is 0.
- Latency: a bundle accepted at edge N is visible on regE_o_* after edge N, i.e. 1 cycle. Throughput is 1 bundle per cycle when execute_i_ready is held high.
- Flush:
  - flush_i has priority over every other event.
  - At the next edge the block enters EMPTY and regE_o_ready becomes 1.
  - A bundle presented by decode in the flush cycle is dropped even if ready was high.
  - A downstream transfer in the flush cycle still counts as consumed by execute.
- Bubble encoding: whenever regE_o_valid = 0, every regE_o_* field drives 0. This holds after reset, after a flush, and after draining.
- Reset (asserted asynchronously):
  - regE_o_valid = 0, regE_o_ready = 0, all data fields = 0, state EMPTY.
  - regE_o_ready goes to 1 on the first clk edge after rst_n deasserts.
  - Reset mid-transfer discards both slots.
- Width rules: no arithmetic is performed; fields pass through bit-exact.
- Simulation-only assertions:
  - Each info vector is $onehot0 on an accepted bundle.
  - opcode_info is never 0 on an accepted valid bundle.

Decomposition:
- Shared package pipe_pkg holds:
  - width constants XLEN, ALU_W, OPC_W, BR_W, LS_W;
  - a packed struct e_bundle_t covering all info fields, data fields and rd;
  - named bit-index constants for the opcode_info and branch_info positions.
- The decode stage and the execute stage import the same pipe_pkg.
- One sub-module, skid_slot: a register of e_bundle_t plus its valid bit, with load and clear controls. It is instantiated twice, for M and S.

Test Plan:
- Reset then stream: release rst_n, hold execute_i_ready=1, send 4 lui bundles with pc=0x1000, 0x1004, 0x1008, 0x100C and opcode_info=12'h800. Required: each pc appears 1 cycle after acceptance, no gaps, and regE_o_ready stays 1.
- Backpressure: execute_i_ready=0 while 3 bundles are offered (pc 0x2000, 0x2004, 0x2008). Required: 0x2000 is held in M, 0x2004 goes to S, regE_o_ready=0, and 0x2008 is not accepted. Then raise ready: outputs 0x2000, 0x2004, 0x2008 in order with none lost or duplicated.
- Flush in TWO with decode valid: pulse flush_i while decode presents pc=0x3000. Required next cycle: regE_o_valid=0, every info field 0, regE_o_ready=1, and 0x3000 never appears.
- Flush during a downstream transfer: M holds pc=0x4000, execute_i_ready=1 and flush_i=1 together. Required: 0x4000 is counted as consumed once, and the block is EMPTY next cycle.
- Async reset mid-stream: drop rst_n between edges while in TWO. Required: valid, ready and all fields read 0 immediately, without waiting for clk.
- Random fuzz: random valid, ready and flush over 10k cycles against a scoreboard queue. Required: in-order delivery, and output stability whenever valid=1 and ready=0.
